// File: rtl/time_us_multi.sv
// Multi-channel microsecond timer: each channel has its own prescaler, counter, compare, capture and overflow logic.
// All outputs are registered in the CLK domain.
module time_us_multi #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1_000_000,
  parameter int CH      = 4,
  parameter int CNT_W   = 16,
  parameter int SAT     = 0
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [CH-1:0]       En,
  input  logic [CH-1:0]       Clr,
  input  logic [CH-1:0]       Cap,
  input  logic [CH*CNT_W-1:0] Cmp_val,
  output logic [CH*CNT_W-1:0] Nus,
  output logic [CH*CNT_W-1:0] Cap_val,
  output logic [CH-1:0]       Cap_vld,
  output logic [CH-1:0]       Match,
  output logic [CH-1:0]       OVERFLW,
  output logic [CH-1:0]       Ovf_stky
);

  localparam int              DIV      = CLK_HZ / TICK_HZ;
  localparam int              PRE_W    = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [CNT_W-1:0] MAX      = '1;
  localparam logic            SAT_MODE = (SAT != 0);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cap;
    logic             r_cap_vld;
    logic             r_match;
    logic             r_ovf;
    logic             r_stky;

    logic             w_tick;
    logic             w_at_max;
    logic             w_step;
    logic [CNT_W-1:0] w_next;
    logic [CNT_W-1:0] w_cmp;

    assign w_cmp    = Cmp_val[i*CNT_W +: CNT_W];
    assign w_tick   = En[i] & ~Clr[i] & (r_pre == PRE_LAST);
    assign w_at_max = (r_cnt == MAX);
    // A step is a tick that actually changes the count; a saturated counter at MAX never steps.
    assign w_step   = w_tick & ~(w_at_max & SAT_MODE);
    assign w_next   = r_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        r_pre     <= '0;
        r_cnt     <= '0;
        r_cap     <= '0;
        r_cap_vld <= 1'b0;
        r_match   <= 1'b0;
        r_ovf     <= 1'b0;
        r_stky    <= 1'b0;
      end else begin
        r_cap_vld <= Cap[i];
        if (Cap[i]) r_cap <= En[i] ? r_cnt : '0;
        if (!En[i] || Clr[i]) begin
          r_pre   <= '0;
          r_cnt   <= '0;
          r_match <= 1'b0;
          r_ovf   <= 1'b0;
          r_stky  <= 1'b0;
        end else begin
          r_pre   <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
          r_match <= w_step && (w_next == w_cmp);
          if (w_step) r_cnt <= w_next;
          if (SAT_MODE) begin
            r_ovf  <= w_step ? (w_next == MAX) : w_at_max;
            r_stky <= r_stky | (w_step && (w_next == MAX));
          end else begin
            r_ovf  <= w_tick & w_at_max;
            r_stky <= r_stky | (w_tick & w_at_max);
          end
        end
      end
    end

    assign Nus[i*CNT_W +: CNT_W]     = r_cnt;
    assign Cap_val[i*CNT_W +: CNT_W] = r_cap;
    assign Cap_vld[i]                = r_cap_vld;
    assign Match[i]                  = r_match;
    assign OVERFLW[i]                = r_ovf;
    assign Ovf_stky[i]               = r_stky;
  end

endmodule

// File: tb/tb_time_us_multi.sv
// Bench for time_us_multi: a default 16-bit wrapping instance plus 4-bit wrapping and saturating instances.
module tb_time_us_multi;

  logic CLK;
  logic RSTn;

  logic [3:0]  a_en, a_clr, a_cap;
  logic [63:0] a_cmp, a_nus, a_capv;
  logic [3:0]  a_vld, a_match, a_ovf, a_stky;

  logic [1:0]  w_en, w_clr, w_cap;
  logic [7:0]  w_cmp, w_nus, w_capv;
  logic [1:0]  w_vld, w_match, w_ovf, w_stky;

  logic [1:0]  s_en, s_clr, s_cap;
  logic [7:0]  s_cmp, s_nus, s_capv;
  logic [1:0]  s_vld, s_match, s_ovf, s_stky;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  time_us_multi u_a (
    .CLK(CLK), .RSTn(RSTn), .En(a_en), .Clr(a_clr), .Cap(a_cap), .Cmp_val(a_cmp),
    .Nus(a_nus), .Cap_val(a_capv), .Cap_vld(a_vld), .Match(a_match),
    .OVERFLW(a_ovf), .Ovf_stky(a_stky)
  );

  time_us_multi #(.CH(2), .CNT_W(4), .SAT(0)) u_w (
    .CLK(CLK), .RSTn(RSTn), .En(w_en), .Clr(w_clr), .Cap(w_cap), .Cmp_val(w_cmp),
    .Nus(w_nus), .Cap_val(w_capv), .Cap_vld(w_vld), .Match(w_match),
    .OVERFLW(w_ovf), .Ovf_stky(w_stky)
  );

  time_us_multi #(.CH(2), .CNT_W(4), .SAT(1)) u_s (
    .CLK(CLK), .RSTn(RSTn), .En(s_en), .Clr(s_clr), .Cap(s_cap), .Cmp_val(s_cmp),
    .Nus(s_nus), .Cap_val(s_capv), .Cap_vld(s_vld), .Match(s_match),
    .OVERFLW(s_ovf), .Ovf_stky(s_stky)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // capture scoreboard for the default instance
  always @(negedge CLK) begin
    if (RSTn) begin
      for (int c = 0; c < 4; c++) begin
        if (a_vld[c]) begin
          if (exp_q.size() == 0) check("cap_unexpected", 32'(c), 32'hFFFF_FFFF);
          else check("cap_val", 32'(a_capv[c*16 +: 16]), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int m_cnt;
    int ovf_low;
    RSTn = 1'b0;
    a_en = '0; a_clr = '0; a_cap = '0; a_cmp = '0;
    w_en = '0; w_clr = '0; w_cap = '0; w_cmp = '0;
    s_en = '0; s_clr = '0; s_cap = '0; s_cmp = '0;
    wait_n(3);
    check("rst_a_nus",  32'(|a_nus), 0);
    check("rst_a_capv", 32'(|a_capv), 0);
    check("rst_a_flags", 32'(|{a_vld, a_match, a_ovf, a_stky}), 0);
    check("rst_ws_all", 32'(|{w_nus, w_capv, w_vld, w_match, w_ovf, w_stky,
                               s_nus, s_capv, s_vld, s_match, s_ovf, s_stky}), 0);
    RSTn = 1'b1;
    wait_n(1);

    // T1: first tick after a full period, then 1000 ticks in 50000 edges
    a_en[0] = 1'b1;
    wait_n(49);
    check("t1_nus_e49", 32'(a_nus[15:0]), 0);
    wait_n(1);
    check("t1_nus_e50", 32'(a_nus[15:0]), 1);
    wait_n(49950);
    check("t1_nus_e50000", 32'(a_nus[15:0]), 1000);
    check("t1_others_idle", 32'(a_nus[63:48] | a_nus[47:32] | a_nus[31:16]), 0);
    check("t1_no_ovf", 32'(a_stky[0]), 0);
    a_cap[0] = 1'b1;
    exp_q.push_back(32'd1000);
    wait_n(1);
    a_cap[0] = 1'b0;
    check("t1_cap_vld", 32'(a_vld[0]), 1);

    // T4: compare at 3 on channel 1, then same-edge capture and clear at 7
    a_cmp[31:16] = 16'd3;
    a_en[1] = 1'b1;
    m_cnt = 0;
    for (int k = 1; k <= 350; k++) begin
      @(negedge CLK);
      if (a_match[1]) begin
        m_cnt++;
        check("t4_match_nus", 32'(a_nus[31:16]), 3);
      end
      if (k == 150) check("t4_match_when_3", 32'(a_match[1]), 1);
    end
    check("t4_match_once", 32'(m_cnt), 1);
    check("t4_nus7", 32'(a_nus[31:16]), 7);
    a_cap[1] = 1'b1;
    a_clr[1] = 1'b1;
    exp_q.push_back(32'd7);
    wait_n(1);
    a_cap[1] = 1'b0;
    a_clr[1] = 1'b0;
    check("t4_clr_nus", 32'(a_nus[31:16]), 0);
    check("t4_vld_hi", 32'(a_vld[1]), 1);
    check("t4_clr_nomatch", 32'(a_match[1]), 0);
    wait_n(1);
    check("t4_vld_lo", 32'(a_vld[1]), 0);

    // T5: drop En mid-count, capture while disabled, re-enable with a fresh prescaler
    wait_n(449);
    check("t5_nus9", 32'(a_nus[31:16]), 9);
    wait_n(20);
    a_en[1] = 1'b0;
    wait_n(1);
    check("t5_off_nus", 32'(a_nus[31:16]), 0);
    check("t5_capv_kept", 32'(a_capv[31:16]), 7);
    a_cap[1] = 1'b1;
    exp_q.push_back(32'd0);
    wait_n(1);
    a_cap[1] = 1'b0;
    check("t5_off_cap_vld", 32'(a_vld[1]), 1);
    a_en[1] = 1'b1;
    wait_n(49);
    check("t5_reen_e49", 32'(a_nus[31:16]), 0);
    wait_n(1);
    check("t5_reen_e50", 32'(a_nus[31:16]), 1);

    // T6: asynchronous reset mid-count on all channels
    a_en = 4'hF;
    a_cap[3] = 1'b1;
    exp_q.push_back(32'd0);
    wait_n(1);
    a_cap[3] = 1'b0;
    wait_n(130);
    check("t6_running", 32'(a_nus[63:48]), 2);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("t6_nus", 32'(|a_nus), 0);
    check("t6_capv", 32'(|a_capv), 0);
    check("t6_flags", 32'(|{a_vld, a_match, a_ovf, a_stky}), 0);
    @(negedge CLK);
    a_en = '0;
    RSTn = 1'b1;
    wait_n(1);

    // T2: 4-bit wrap, Cmp_val = 0 matches only on the wrap
    w_cmp[3:0] = 4'd0;
    w_en[0] = 1'b1;
    m_cnt = 0;
    for (int k = 1; k <= 801; k++) begin
      @(negedge CLK);
      if (w_match[0]) begin
        m_cnt++;
        check("t2_match_wrap", 32'(w_nus[3:0]), 0);
      end
      if (k == 799) begin
        check("t2_nus15", 32'(w_nus[3:0]), 15);
        check("t2_ovf_pre", 32'(w_ovf[0]), 0);
        check("t2_stky_pre", 32'(w_stky[0]), 0);
      end
      if (k == 800) begin
        check("t2_nus_wrap", 32'(w_nus[3:0]), 0);
        check("t2_ovf_pulse", 32'(w_ovf[0]), 1);
        check("t2_stky_set", 32'(w_stky[0]), 1);
      end
      if (k == 801) begin
        check("t2_ovf_end", 32'(w_ovf[0]), 0);
        check("t2_stky_hold", 32'(w_stky[0]), 1);
      end
    end
    check("t2_match_once", 32'(m_cnt), 1);
    check("t2_ch1_idle", 32'(w_nus[7:4]), 0);
    w_clr[0] = 1'b1;
    wait_n(1);
    w_clr[0] = 1'b0;
    check("t2_clr_stky", 32'(w_stky[0]), 0);
    check("t2_clr_nus", 32'(w_nus[3:0]), 0);
    wait_n(49);
    check("t2_restart_e49", 32'(w_nus[3:0]), 0);
    wait_n(1);
    check("t2_restart_e50", 32'(w_nus[3:0]), 1);

    // T3: 4-bit saturate, compare at MAX
    s_cmp[3:0] = 4'd15;
    s_en[0] = 1'b1;
    m_cnt = 0;
    ovf_low = 0;
    for (int k = 1; k <= 950; k++) begin
      @(negedge CLK);
      if (s_match[0]) m_cnt++;
      if (k == 749) begin
        check("t3_nus14", 32'(s_nus[3:0]), 14);
        check("t3_ovf_pre", 32'(s_ovf[0]), 0);
      end
      if (k == 750) begin
        check("t3_match_at_max", 32'(s_match[0]), 1);
        check("t3_stky_set", 32'(s_stky[0]), 1);
      end
      if (k >= 750 && !s_ovf[0]) ovf_low++;
    end
    check("t3_ovf_level", 32'(ovf_low), 0);
    check("t3_match_once", 32'(m_cnt), 1);
    check("t3_nus_hold", 32'(s_nus[3:0]), 15);

    wait_n(2);
    check("cap_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
